// File: rtl/shift_cmd_seq.sv
// Command sequencer for a universal shift register: accepts a word over valid/ready,
// issues one parallel load, up to W serial shifts from ser_in, then hold with a done pulse.
module shift_cmd_seq #(
   parameter int W     = 8,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [W-1:0]     cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_len,
   input  logic             ser_in,
   output logic [1:0]       cntrl,
   output logic [W-1:0]     d_in,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(W);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [W-1:0]     data_r;
   logic             dir_r;
   logic [CNT_W-1:0] remaining_r;
   logic [CNT_W-1:0] len_clamp_s;
   logic             accept_s;

   // Oversized lengths clamp to a full-width shift so the counter never exceeds W
   assign len_clamp_s = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
   assign accept_s    = cmd_valid && (state_r == ST_IDLE);

   // State register, captured command and remaining-shift counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         data_r      <= {W{1'b0}};
         dir_r       <= 1'b0;
         remaining_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            data_r      <= cmd_data;
            dir_r       <= cmd_dir;
            remaining_r <= len_clamp_s;
         end else if (state_r == ST_SHIFT) begin
            remaining_r <= remaining_r - CNT_W'(1);
         end else begin
            remaining_r <= remaining_r;
         end
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (remaining_r == {CNT_W{1'b0}}) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (remaining_r == CNT_W'(1)) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_DONE:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode; in SHIFT the serial bit is steered to the entry end of the register
   always_comb begin
      cntrl     = 2'b00;
      d_in      = {W{1'b0}};
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cmd_ready = 1'b1;
         end
         ST_LOAD: begin
            cntrl = 2'b11;
            d_in  = data_r;
            busy  = 1'b1;
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (dir_r) begin
               cntrl = 2'b10;
               d_in  = {ser_in, {(W-1){1'b0}}};
            end else begin
               cntrl = 2'b01;
               d_in  = {{(W-1){1'b0}}, ser_in};
            end
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Scoreboard bench for shift_cmd_seq: stimulus queues the expected per-cycle trace and
// final register value; a negedge monitor records DUT activity and compares on done.
module tb_shift_cmd_seq;
   localparam int W     = 8;
   localparam int CNT_W = $clog2(W + 1);

   typedef struct packed {
      int                   n;
      logic [W-1:0]         q;
      logic [(W+2)*2-1:0]   c;
      logic [(W+2)*W-1:0]   d;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [W-1:0]     cmd_data;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_len;
   logic             ser_in;
   logic [1:0]       cntrl;
   logic [W-1:0]     d_in;
   logic             busy;
   logic             done;

   logic [W-1:0]     q_out;
   exp_t             exp_q[$];
   int               checks   = 0;
   int               failures = 0;
   int               cyc      = 0;
   int               last_done_cyc = -100;
   logic [1:0]       tr_c [0:W+1];
   logic [W-1:0]     tr_d [0:W+1];
   int               tr_n = 0;
   int               wd   = 0;

   shift_cmd_seq #(.W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_len(cmd_len), .ser_in(ser_in),
      .cntrl(cntrl), .d_in(d_in), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Downstream universal shift register and cycle counter
   always @(posedge clk) begin
      cyc <= cyc + 1;
      case (cntrl)
         2'b01:   q_out <= {q_out[W-2:0], d_in[0]};
         2'b10:   q_out <= {d_in[W-1], q_out[W-1:1]};
         2'b11:   q_out <= d_in;
         default: q_out <= q_out;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: record busy-cycle trace, compare against the scoreboard on done
   always @(negedge clk) begin
      if (!rst_n) begin
         tr_n = 0;
         wd   = 0;
      end else begin
         chk("ready_vs_busy", cmd_ready, !busy);
         if (busy) begin
            if (tr_n < W + 2) begin
               tr_c[tr_n] = cntrl;
               tr_d[tr_n] = d_in;
            end
            tr_n++;
         end else begin
            chk("idle_outputs", {done, cntrl, d_in}, '0);
         end
         if (done) begin
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("busy_cycles", tr_n, e.n);
               for (int i = 0; i < e.n && i < tr_n && i < W + 2; i++) begin
                  chk("cntrl", tr_c[i], e.c[i*2 +: 2]);
                  chk("d_in", tr_d[i], e.d[i*W +: W]);
               end
               chk("q_out", q_out, e.q);
            end
            tr_n = 0;
            wd   = 0;
         end else if (exp_q.size() != 0) begin
            wd++;
            if (wd > 100) begin
               chk("done_timeout", wd, 0);
               void'(exp_q.pop_front());
               wd = 0;
            end
         end
      end
   end

   // One command: enqueue expectation, handshake, feed serial bits; optional mid-shift reset
   task automatic run_cmd(input logic [W-1:0] data, input logic dir, input logic [CNT_W-1:0] len,
                          input logic [W-1:0] bits, input bit hold, input int abort_at,
                          input bit chk_gap);
      exp_t       e;
      int         n;
      logic [W-1:0] q;
      logic [W-1:0] bv;
      bit         acc;
      n = (int'(len) > W) ? W : int'(len);
      e = '0;
      e.n = n + 2;
      e.c[1:0] = 2'b11;
      e.d[W-1:0] = data;
      q = dir ? (data >> n) : (data << n);
      for (int i = 0; i < n; i++) begin
         bv = {{(W-1){1'b0}}, bits[i]};
         e.c[(i+1)*2 +: 2] = dir ? 2'b10 : 2'b01;
         e.d[(i+1)*W +: W] = dir ? (bv << (W - 1)) : bv;
         q = q | (dir ? (bv << (W - n + i)) : (bv << (n - 1 - i)));
      end
      e.q = q;
      exp_q.push_back(e);

      cmd_data  = data;
      cmd_dir   = dir;
      cmd_len   = len;
      cmd_valid = 1'b1;
      acc = 0;
      for (int k = 0; k < 64 && !acc; k++) begin
         @(negedge clk);
         if (cmd_ready) acc = 1;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         chk("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      if (chk_gap) chk("accept_gap", cyc, last_done_cyc + 2);
      if (!hold) cmd_valid = 1'b0;
      cmd_data = W'($urandom);
      cmd_dir  = 1'($urandom);
      cmd_len  = CNT_W'($urandom);
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         ser_in = bits[i];
         if (i == abort_at) begin
            rst_n = 1'b0;
            exp_q.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("abort_cntrl", cntrl, 2'b00);
            chk("abort_busy", busy, 1'b0);
            chk("abort_ready", cmd_ready, 1'b1);
            chk("abort_done", done, 1'b0);
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      ser_in = 1'($urandom);
   endtask

   initial begin
      bit prev_hold;
      bit hold;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      cmd_dir   = 1'b0;
      cmd_len   = '0;
      ser_in    = 1'b0;
      q_out     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cntrl", cntrl, 2'b00);
      chk("rst_d_in", d_in, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ready", cmd_ready, 1'b1);
      @(posedge clk);
      #1;

      run_cmd(8'hA5, 1'b0, 4'd0,  8'h00,        0, -1, 0);
      repeat (2) @(posedge clk);
      #1;
      run_cmd(8'h81, 1'b0, 4'd3,  8'b0000_0101, 0, -1, 0);
      repeat (2) @(posedge clk);
      #1;
      run_cmd(8'h81, 1'b1, 4'd2,  8'b0000_0011, 0, -1, 0);
      repeat (2) @(posedge clk);
      #1;
      run_cmd(8'hFF, 1'b0, 4'd12, 8'h00,        0, -1, 0);
      repeat (2) @(posedge clk);
      #1;
      run_cmd(8'h3C, 1'b0, 4'd4,  8'h96,        1, -1, 0);
      run_cmd(8'hC3, 1'b1, 4'd5,  8'h5A,        0, -1, 1);
      repeat (2) @(posedge clk);
      #1;
      run_cmd(8'h5A, 1'b0, 4'd5,  8'hFF,        0,  1, 0);
      run_cmd(8'h12, 1'b1, 4'd3,  8'h05,        0, -1, 0);

      prev_hold = 0;
      for (int t = 0; t < 24; t++) begin
         hold = (t != 23) && ($urandom_range(0, 3) == 0);
         if (!prev_hold) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         run_cmd(W'($urandom), 1'($urandom), CNT_W'($urandom_range(0, 15)), W'($urandom),
                 hold, -1, prev_hold);
         prev_hold = hold;
      end

      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
